// File: rtl/op_share_ctrl_pkg.sv
// Shared encodings and default sizes for the operand-sharing controller slice.
// Contents: FSM state enum, default client count/width, index-width helper.
// Imported by the interface, the round-robin picker and the controller top.
package op_share_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    OPER = 2'b10,
    DONE = 2'b11
  } state_t;

  // Bits needed to hold a client index 0..n-1 (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/op_share_ctrl_if.sv
// Bundle of client-side and datapath-side signals around op_share_ctrl.
// Client side: req, a_in, b_in (in); gnt, done, res, busy (out).
// Datapath side: dp_a, dp_b, hab_a, hab_b, hab_op (out); fim_a, fim_b, fim_op, dp_res (in).
interface op_share_ctrl_if
  import op_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) ();

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [2*W-1:0]    res;
  logic              busy;
  logic [W-1:0]      dp_a;
  logic [W-1:0]      dp_b;
  logic              hab_a;
  logic              hab_b;
  logic              hab_op;
  logic              fim_a;
  logic              fim_b;
  logic              fim_op;
  logic [2*W-1:0]    dp_res;

  // master: the clients plus the datapath (environment)
  modport master (
    output req, a_in, b_in, fim_a, fim_b, fim_op, dp_res,
    input  gnt, done, res, busy, dp_a, dp_b, hab_a, hab_b, hab_op
  );

  // slave: the controller
  modport slave (
    input  req, a_in, b_in, fim_a, fim_b, fim_op, dp_res,
    output gnt, done, res, busy, dp_a, dp_b, hab_a, hab_b, hab_op
  );

endinterface

// File: rtl/op_share_ctrl_rr_pick.sv
// Combinational round-robin selector: first requester after 'last', wrapping mod NREQ.
// Latency: zero cycles (pure combinational).
// Ports: req (requests), last (previous owner) -> sel (chosen index), any_req (|req).
module rr_pick
  import op_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_w(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   sel,
  output logic            any_req
);

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NREQ);
  endfunction

  // Walk offsets from farthest to nearest so the nearest requester after
  // 'last' is the final (winning) assignment; works for any NREQ.
  always_comb begin
    sel = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req[wrap(int'(last) + i)]) sel = wrap(int'(last) + i);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/op_share_ctrl.sv
// Round-robin controller sharing one load/operate datapath among NREQ clients.
// Latency: grant edge -> LOAD -> OPER -> DONE, minimum 3 cycles to done, then one IDLE cycle.
// Backpressure: LOAD waits on fim_a & fim_b, OPER waits on fim_op; clients hold req until done.
// Ports: clk, rst (async, active-high), bus (op_share_ctrl_if.slave: client + datapath signals).
module op_share_ctrl
  import op_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input logic             clk,
  input logic             rst,
  op_share_ctrl_if.slave  bus
);

  localparam int IW = idx_w(NREQ);

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last;
  logic [IW-1:0]   sel;
  logic            any_req;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic [2*W-1:0]  res_q;
  logic [W-1:0]    dp_a_q;
  logic [W-1:0]    dp_b_q;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req     (bus.req),
    .last    (last),
    .sel     (sel),
    .any_req (any_req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      last   <= IW'(NREQ - 1);
      gnt_q  <= '0;
      done_q <= '0;
      res_q  <= '0;
      dp_a_q <= '0;
      dp_b_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_q  <= NREQ'(1) << sel;
            dp_a_q <= bus.a_in[sel*W +: W];
            dp_b_q <= bus.b_in[sel*W +: W];
            owner  <= sel;
            state  <= LOAD;
          end
        end
        LOAD: begin
          // fim_a/fim_b are levels, so both simply have to be high together.
          if (bus.fim_a && bus.fim_b) state <= OPER;
        end
        OPER: begin
          if (bus.fim_op) begin
            res_q  <= bus.dp_res;
            done_q <= NREQ'(1) << owner;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= '0;
          gnt_q  <= '0;
          last   <= owner;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.res    = res_q;
  assign bus.dp_a   = dp_a_q;
  assign bus.dp_b   = dp_b_q;
  assign bus.busy   = (state != IDLE);
  assign bus.hab_a  = (state == LOAD);
  assign bus.hab_b  = (state == LOAD);
  assign bus.hab_op = (state == OPER);

endmodule

// File: tb/tb_op_share_ctrl.sv
// Self-checking bench for op_share_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a service-level model of the arbitration rules.
module tb_op_share_ctrl;
  import op_share_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  op_share_ctrl_if #(.NREQ(NREQ), .W(W)) bus ();

  op_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (service level) ----------------
  // Tracks which client is being served and which phase of its service we
  // are in: 0 = waiting, 1 = loading operands, 2 = operating, 3 = reporting.
  int             m_phase;
  int             m_owner;
  int             m_last;
  int             m_pick;
  logic [W-1:0]   m_a, m_b;
  logic [2*W-1:0] m_res;
  int             m_services = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_owner = 0; m_last = NREQ - 1;
      m_a = '0; m_b = '0; m_res = '0;
    end else begin
      case (m_phase)
        0: begin
          m_pick = -1;
          for (int i = 1; i <= NREQ; i++)
            if (m_pick < 0 && ((int'(bus.req) >> ((m_last + i) % NREQ)) & 1) == 1)
              m_pick = (m_last + i) % NREQ;
          if (m_pick >= 0) begin
            m_owner = m_pick;
            m_a = W'(bus.a_in >> (m_pick * W));
            m_b = W'(bus.b_in >> (m_pick * W));
            m_phase = 1;
          end
        end
        1: if (bus.fim_a && bus.fim_b) m_phase = 2;
        2: if (bus.fim_op) begin m_res = bus.dp_res; m_phase = 3; end
        default: begin m_last = m_owner; m_phase = 0; m_services++; end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("gnt",    64'(bus.gnt),    (m_phase != 0) ? (64'd1 << m_owner) : 64'd0);
      chk("done",   64'(bus.done),   (m_phase == 3) ? (64'd1 << m_owner) : 64'd0);
      chk("busy",   64'(bus.busy),   64'(m_phase != 0));
      chk("hab_a",  64'(bus.hab_a),  64'(m_phase == 1));
      chk("hab_b",  64'(bus.hab_b),  64'(m_phase == 1));
      chk("hab_op", 64'(bus.hab_op), 64'(m_phase == 2));
      chk("dp_a",   64'(bus.dp_a),   64'(m_a));
      chk("dp_b",   64'(bus.dp_b),   64'(m_b));
      chk("res",    64'(bus.res),    64'(m_res));
      chk("onehot", 64'($onehot0(bus.gnt) && $onehot0(bus.done)), 64'd1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req = '0; bus.a_in = '0; bus.b_in = '0;
    bus.fim_a = 1'b0; bus.fim_b = 1'b0; bus.fim_op = 1'b0; bus.dp_res = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int maxc, output logic [NREQ-1:0] d);
    d = '0;
    for (int c = 0; c < maxc; c++) begin
      tick();
      if (bus.done != '0) begin
        d = bus.done;
        return;
      end
    end
    chk("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_gnt(input int maxc, output logic [NREQ-1:0] g);
    g = '0;
    for (int c = 0; c < maxc; c++) begin
      tick();
      if (bus.gnt != '0) begin
        g = bus.gnt;
        return;
      end
    end
    chk("gnt_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    logic [NREQ-1:0] d, g;
    int ord[$];
    int cyc[$];
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int cnt;
    int n_before;

    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_gnt",  64'(bus.gnt),  64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_res",  64'(bus.res),  64'd0);
    chk("rst_hab",  64'({bus.hab_a, bus.hab_b, bus.hab_op}), 64'd0);
    do_reset();
    cmp_en = 1'b1;

    // Single request, all fims high: 3 cycles to done, result 15.
    bus.req = 4'b0001; bus.a_in = 32'h0000_0003; bus.b_in = 32'h0000_0005;
    bus.fim_a = 1'b1; bus.fim_b = 1'b1; bus.fim_op = 1'b1; bus.dp_res = 16'd15;
    tick();
    chk("t1_gnt_load", 64'(bus.gnt), 64'h1);
    chk("t1_hab_ab",   64'({bus.hab_a, bus.hab_b, bus.hab_op}), 64'b110);
    tick();
    chk("t1_hab_op",   64'({bus.hab_a, bus.hab_b, bus.hab_op}), 64'b001);
    tick();
    chk("t1_done",     64'(bus.done), 64'h1);
    chk("t1_res",      64'(bus.res),  64'd15);
    bus.req = '0;
    tick();
    chk("t1_idle",     64'({bus.gnt, bus.busy}), 64'd0);
    chk("t1_res_held", 64'(bus.res), 64'd15);

    // All clients requesting: rotation 0,1,2,3,0 with done every 4 cycles.
    do_reset();
    bus.req = 4'b1111; bus.fim_a = 1'b1; bus.fim_b = 1'b1; bus.fim_op = 1'b1;
    bus.a_in = 32'h4433_2211; bus.b_in = 32'h8877_6655; bus.dp_res = 16'h1234;
    for (int c = 0; c < 40 && ord.size() < 5; c++) begin
      tick();
      if (bus.done != '0) begin
        ord.push_back($clog2(bus.done));
        cyc.push_back(c);
      end
    end
    chk("t2_count", 64'(ord.size()), 64'd5);
    for (int k = 0; k < ord.size() && k < 5; k++) begin
      chk("t2_order", 64'(ord[k]), 64'(exp_ord[k]));
      if (k > 0) chk("t2_spacing", 64'(cyc[k] - cyc[k-1]), 64'd4);
    end

    // Staggered fims: four LOAD cycles, early fim_op ignored.
    do_reset();
    bus.req = 4'b0001; bus.a_in = 32'h0000_0011; bus.b_in = 32'h0000_0022;
    tick();
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (!bus.hab_a) break;
      cnt++;
      bus.fim_op = (c == 0);
      bus.fim_a  = (c >= 1);
      bus.fim_b  = (c >= 3);
      tick();
    end
    chk("t3_load_cycles", 64'(cnt), 64'd4);
    chk("t3_in_oper",     64'(bus.hab_op), 64'd1);
    bus.dp_res = 16'h0242; bus.fim_op = 1'b1;
    wait_done(5, d);
    chk("t3_done", 64'(d), 64'h1);
    chk("t3_res",  64'(bus.res), 64'h0242);
    bus.req = '0;

    // Operand change after grant has no effect on dp_a.
    do_reset();
    bus.req = 4'b0010; bus.a_in = 32'h0000_0700; bus.b_in = 32'h0000_0200;
    bus.fim_a = 1'b1; bus.fim_b = 1'b1; bus.fim_op = 1'b0; bus.dp_res = 16'd14;
    tick();
    bus.a_in = 32'h0000_0900;
    chk("t4_gnt",  64'(bus.gnt),  64'h2);
    chk("t4_dp_a", 64'(bus.dp_a), 64'd7);
    tick();
    tick();
    chk("t4_dp_a_oper", 64'(bus.dp_a), 64'd7);
    bus.fim_op = 1'b1;
    wait_done(5, d);
    chk("t4_done", 64'(d), 64'h2);
    chk("t4_dp_a_done", 64'(bus.dp_a), 64'd7);
    chk("t4_res", 64'(bus.res), 64'd14);
    bus.req = '0;

    // Request dropped mid-service still completes; next grant to client 3.
    do_reset();
    bus.req = 4'b0100; bus.fim_a = 1'b1; bus.fim_b = 1'b1; bus.fim_op = 1'b0;
    tick();
    chk("t5_gnt", 64'(bus.gnt), 64'h4);
    tick();
    chk("t5_oper", 64'(bus.hab_op), 64'd1);
    bus.req = 4'b1000; bus.fim_op = 1'b1;
    wait_done(5, d);
    chk("t5_done", 64'(d), 64'h4);
    wait_gnt(5, g);
    chk("t5_next_gnt", 64'(g), 64'h8);
    bus.req = '0;
    wait_done(5, d);

    // Reset in OPER clears everything at once; pointer restarts at client 0.
    do_reset();
    bus.req = 4'b1111; bus.a_in = 32'h5555_5555; bus.b_in = 32'h3333_3333;
    bus.fim_a = 1'b1; bus.fim_b = 1'b1; bus.fim_op = 1'b0;
    tick();
    tick();
    chk("t6_oper", 64'(bus.hab_op), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", 64'({bus.gnt, bus.done, bus.busy, bus.hab_op}), 64'd0);
    chk("t6_rst_data", 64'({bus.dp_a, bus.dp_b, bus.res}), 64'd0);
    bus.req = 4'b1010;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_first_gnt", 64'(bus.gnt), 64'h2);
    bus.req = '0; bus.fim_op = 1'b1;
    wait_done(5, d);
    chk("t6_done", 64'(d), 64'h2);

    // Randomized traffic against the model.
    do_reset();
    n_before = m_services;
    for (int c = 0; c < 3000; c++) begin
      bus.req    = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      bus.a_in   = $urandom;
      bus.b_in   = $urandom;
      bus.fim_a  = ($urandom_range(0, 3) != 0);
      bus.fim_b  = ($urandom_range(0, 3) != 0);
      bus.fim_op = ($urandom_range(0, 2) != 0);
      bus.dp_res = 16'($urandom);
      if (c == 1500) begin
        #2;
        rst = 1'b1;
        #1;
        chk("rand_rst_busy", 64'(bus.busy), 64'd0);
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    chk("rand_services", 64'((m_services - n_before) > 100), 64'd1);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/op_share_ctrl.md
Name: op_share_ctrl

Overview:
Round-robin controller that shares one load/operate datapath (operand registers A/B plus a multi-cycle operator) among NREQ requesters. It grants one client at a time and captures that client's operands. It then sequences the datapath through load-operands and operate phases using hab/fim handshakes, and returns the result to the granted client with a one-cycle done pulse. It sits between the client ports and the existing datapath.

Parameters:
NREQ, 4, number of requesting clients (2..8)
W, 8, operand width in bits; result width is 2*W

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req  in  NREQ  per-client service request, level
a_in  in  NREQ*W  client operands A, client i at bits [i*W +: W]
b_in  in  NREQ*W  client operands B, same packing
gnt  out  NREQ  one-hot grant, held for the whole service
done  out  NREQ  one-cycle pulse to the served client
res  out  2*W  result register, valid when done pulses, held until next DONE
busy  out  1  high whenever state != IDLE
dp_a  out  W  captured operand A to datapath
dp_b  out  W  captured operand B to datapath
hab_a  out  1  enable load of operand A
hab_b  out  1  enable load of operand B
hab_op  out  1  enable operator
fim_a  in  1  operand A load finished (level)
fim_b  in  1  operand B load finished (level)
fim_op  in  1  operation finished, dp_res valid
dp_res  in  2*W  datapath result

Behaviour:
- Reset: state=IDLE; gnt, done, res, dp_a, dp_b, hab_a, hab_b, hab_op = 0; busy=0; priority pointer last=NREQ-1, so client 0 has top priority.
- States are IDLE, LOAD, OPER and DONE. hab_* and busy are Moore outputs, decoded combinationally from state.
- IDLE: if |req at the clock edge, select the first requesting index scanning last+1, last+2, ... (mod NREQ). Register gnt=onehot(sel), dp_a=a_in[sel], dp_b=b_in[sel], owner=sel, and go to LOAD. Otherwise stay in IDLE.
- LOAD: hab_a=hab_b=1. Go to OPER on the edge where fim_a & fim_b=1. fim_a and fim_b may rise on different cycles, and no latching is needed because both are levels. fim_op is ignored in this state.
- OPER: hab_op=1. On the edge where fim_op=1, set res<=dp_res and go to DONE. fim_a and fim_b are ignored in this state.
- DONE: done[owner]=1 for exactly this cycle. Registered transition: gnt<=0, last<=owner, go to IDLE.
- Latency: if req is seen at edge k and all fims are already high, then LOAD runs k+1, OPER k+2, DONE k+3. Minimum is 3 cycles from the request edge to done. There is always one IDLE cycle between consecutive services.
- Operands are captured only at the grant edge. Later changes to a_in/b_in have no effect.
- If req[owner] drops mid-service, the service still completes and done still pulses. Clients must hold req until done. A req still high after done is treated as a new request and arbitrated normally.
- Fairness: with all clients requesting continuously, grants rotate 0,1,2,...,NREQ-1,0.
- Reset mid-operation returns everything to reset values immediately (asynchronously). No done is issued and the pointer is reset.
- gnt and done are never multi-hot. done is asserted only while gnt[owner]=1 in the DONE cycle.
- Arithmetic: the index wrap is modulo NREQ, and NREQ need not be a power of 2. Widths are exact and nothing is truncated.

Decomposition:
- Shared package op_share_pkg holds the state encodings (IDLE=2'b00, LOAD=2'b01, OPER=2'b10, DONE=2'b11) and the default widths.
- One sub-module, rr_pick: combinational round-robin selector with inputs req[NREQ] and last. Outputs are sel index and any_req.

Test Plan:
- Single request: req=0001, a=3, b=5, fims tied high, dp_res=15 -> gnt=0001 from k+1; hab_a/hab_b high 1 cycle, hab_op high 1 cycle; done=0001 at k+3; res=15.
- All requesting: req=1111 held, fims tied high -> gnt order 0,1,2,3,0; each done 4 cycles apart; done is never multi-hot.
- Staggered fims: fim_a high at LOAD+1, fim_b high at LOAD+3 -> stays in LOAD 4 cycles; enters OPER only after both are high; an early fim_op pulse during LOAD is ignored.
- Operand change: a_in[1] changes 7->9 one cycle after grant to client 1 -> dp_a stays 7 through the service.
- Request drop: req[2] deasserted during OPER -> service completes, done[2] pulses, next grant goes to client 3 if it is requesting.
- Reset mid-OPER: rst asserted -> all outputs 0 immediately, no done; after release with req=1010, client 1 is granted first.
